// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
//
// Computes WIDTH-bit additions by time-multiplexing a single 4-bit
// ripple-carry adder slice. Operands are captured through a valid/ready
// handshake. One slice is processed per clock, least-significant slice
// first. The carry is held in a register between slices. The finished result
// is offered through a second valid/ready handshake.
//
// Compared with a fully parallel WIDTH-bit adder, this block uses less
// logic but takes longer: the latency is SLICES = WIDTH/4 cycles.
//
// Optional feature:
//   ADD_SUB_EN - when this macro is defined, the 'sub' port exists. With
//                sub=1 the block computes a - b: each slice adds ~b and the
//                initial carry is forced to 1. In that case cout=1 means no
//                borrow occurred. When the macro is undefined, the block is
//                add-only.
//
// Parameters:
//   WIDTH      operand/result width; must be a multiple of 4 and >= 8
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   operand source presents a request
//   in_ready   block can accept a request (high only while idle)
//   a, b       operands
//   cin        carry into slice 0
//   sub        subtract request (only with ADD_SUB_EN)
//   out_valid  sum/cout hold a completed result
//   out_ready  consumer takes the result
//   sum        registered result
//   cout       registered carry out of the top slice
//   busy       high whenever an operation is in progress or pending pickup
// ---------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int SLICES = WIDTH / 4;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sub_reg;
    logic             carry;
    logic [IDX_W-1:0] slice_idx;

    logic             sub_in;
    logic             accept;
    logic             last_slice;
    logic             take_result;

    logic [3:0]       a_slice;
    logic [3:0]       b_slice;
    logic [3:0]       slice_sum;
    logic [4:0]       ripple;

`ifdef ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake decode. in_ready and busy depend only
    // on the registered state, so there is no combinational path from the
    // inputs to them.
    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        accept      = 1'b0;
        last_slice  = 1'b0;
        take_result = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (slice_idx == LAST_IDX) begin
                    last_slice = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    take_result = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One 4-bit ripple-carry slice. {slice_idx, 2'b00} is slice_idx*4,
    // which is the bit offset of the current slice. For subtraction the
    // B slice is inverted here, and the +1 comes from the initial carry.
    always_comb begin
        a_slice   = a_reg[{slice_idx, 2'b00} +: 4];
        b_slice   = b_reg[{slice_idx, 2'b00} +: 4] ^ {4{sub_reg}};
        ripple    = '0;
        slice_sum = '0;
        ripple[0] = carry;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i]  = a_slice[i] ^ b_slice[i] ^ ripple[i];
            ripple[i + 1] = (a_slice[i] & b_slice[i])
                          | (ripple[i] & (a_slice[i] ^ b_slice[i]));
        end
    end

    // Operand latches, carry register, slice counter and result registers.
    // The result is cleared on accept. Because of this, a stale sum from an
    // earlier operation is never mixed into a new one. If reset aborts an
    // operation midway, the partial sum is wiped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry     <= 1'b0;
            slice_idx <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= sub_in;
            carry     <= sub_in | cin;
            slice_idx <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == RUN) begin
            sum[{slice_idx, 2'b00} +: 4] <= slice_sum;
            carry     <= ripple[4];
            slice_idx <= slice_idx + 1'b1;
            if (last_slice) begin
                cout      <= ripple[4];
                out_valid <= 1'b1;
            end
        end else if (take_result) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wide_add_sequencer
//
// Directed testbench for wide_add_sequencer with WIDTH=16.
//
// Expected results are pushed into a scoreboard queue when each request is
// issued. A monitor process pops the queue and compares the entry whenever
// the DUT completes a result handshake. The stimulus thread also checks the
// reset values, the latency, the busy duration, backpressure behaviour and
// abort-on-reset behaviour directly.
//
// Subtract vectors are included when ADD_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_wide_add_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    // Each entry is {cout, sum}.
    logic [16:0] exp_q[$];

    wide_add_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleValues(input string tag);
        checkOutput({tag, " in_ready"},  32'(in_ready),  32'd1);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " busy"},      32'(busy),      32'd0);
        checkOutput({tag, " sum"},       32'(sum),       32'h0000);
        checkOutput({tag, " cout"},      32'(cout),      32'd0);
    endtask

    // Waits for in_ready, then presents one request and returns #1 after the
    // accepting edge. The operand inputs are then scrambled to show that
    // they are no longer used.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vcin, input logic vsub,
                                 input logic [15:0] exp_sum, input logic exp_cout,
                                 input bit push);
        int waited = 0;
        while (!in_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL in_ready timeout: got 0, expected 1");
        end
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        if (push) exp_q.push_back({exp_cout, exp_sum});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = ~vcin;
        sub      = ~vsub;
    endtask

    task automatic waitIdle();
        int waited = 0;
        while ((busy || out_valid) && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (busy || out_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idle timeout: got busy=%0b, expected 0", busy);
        end
    endtask

    task automatic waitValid();
        int waited = 0;
        while (!out_valid && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!out_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL out_valid timeout: got 0, expected 1");
        end
    endtask

    // Scoreboard monitor: compares each completed result handshake.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected result: got sum=0x%0h, expected none", sum);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result sum",  32'(sum),  32'(e[15:0]));
                    checkOutput("result cout", 32'(cout), 32'(e[16]));
                end
            end
        end
    end

    initial begin
        logic [15:0] va[4];
        logic [15:0] vb[4];
        logic        vc[4];
        logic [15:0] vs[4];
        logic        vo[4];
        int          lat;
        int          busy_cnt;

        va = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h0F0F};
        vb = '{16'h0000, 16'h8000, 16'hFFFF, 16'h00F1};
        vc = '{1'b1,     1'b0,     1'b1,     1'b0};
        vs = '{16'h0000, 16'h0000, 16'hFFFF, 16'h1000};
        vo = '{1'b1,     1'b1,     1'b1,     1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset values while reset is held, then after it is released.
        #2;
        checkIdleValues("in reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleValues("after reset");

        // Basic add: latency and busy duration.
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b1);
        lat      = -1;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat < 0) lat = i;
            if (busy) busy_cnt++;
        end
        checkOutput("latency edges", 32'(lat), 32'd4);
        checkOutput("busy cycles", 32'(busy_cnt), 32'd5);

        // Carry ripple and boundary vectors.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(va[i], vb[i], vc[i], 1'b0, vs[i], vo[i], 1'b1);
            waitIdle();
        end

        // Backpressure: the result is held and a second request is ignored.
        out_ready = 1'b0;
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);
        waitValid();
        for (int i = 0; i < 3; i++) begin
            a        = 16'h1111;
            b        = 16'h2222;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("bp sum held",  32'(sum),       32'h0100);
            checkOutput("bp cout held", 32'(cout),      32'd0);
            checkOutput("bp in_ready",  32'(in_ready),  32'd0);
            checkOutput("bp out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp in_ready back", 32'(in_ready),  32'd1);
        checkOutput("bp out_valid low", 32'(out_valid), 32'd0);
        checkOutput("bp sum kept",      32'(sum),       32'h0100);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp no extra accept", 32'(busy), 32'd0);

        // Reset two cycles into an operation aborts it without any output.
        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre-abort busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkIdleValues("mid-op reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("aborted op out_valid", 32'(out_valid), 32'd0);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1);
        waitIdle();

`ifdef ADD_SUB_EN
        // Subtraction: cin is ignored; cout=1 means no borrow.
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b1);
        waitIdle();
`endif

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
